// File: rtl/mod_pkg.sv
// Shared types and constants for the on-off-keying modulator and its consumers.
package mod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic START_SYM  = 1'b1;
  localparam logic STOP_SYM   = 1'b0;

  // clk cycles per clk_m period as produced by the clock generator
  localparam int   SYM_PERIOD = 12500;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on each rising edge of a signal that is already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in;
    end
  end

  assign pulse = in & ~in_d;

endmodule

// File: rtl/ook_modulator.sv
// OOK modulator: serialises one word per frame (start, DATA_W bits MSB first, stop)
// at the clk_m symbol rate and gates the carrier with the registered symbol.
module ook_modulator
  import mod_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_m,
  input  logic              carrier,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              bit_out,
  output logic              mod_out,
  output logic              tx_done
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic                sym_tick;

  rise_detect u_sym_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (clk_m),
    .pulse (sym_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      bit_out <= STOP_SYM;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        // a tick coinciding with acceptance is deliberately not acted on here
        IDLE: begin
          if (tx_valid) begin
            shreg <= tx_data;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sym_tick) begin
            bit_out <= START_SYM;
            state   <= START;
          end
        end
        START: begin
          if (sym_tick) begin
            bit_out <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            bit_cnt <= CNT_LAST;
            state   <= DATA;
          end
        end
        DATA: begin
          if (sym_tick) begin
            if (bit_cnt == '0) begin
              bit_out <= STOP_SYM;
              state   <= STOP;
            end else begin
              bit_out <= shreg[DATA_W-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        STOP: begin
          if (sym_tick) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign mod_out  = carrier & bit_out;

endmodule

// File: tb/tb_ook_modulator.sv
// Directed bench for ook_modulator with a shortened clk_m period driven locally.
module tb_ook_modulator;

  localparam int DATA_W = 8;
  localparam int P      = 40;  // clk_m period in clk cycles
  localparam int CP     = 5;   // carrier period in clk cycles

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              clk_m    = 1'b0;
  logic              carrier  = 1'b0;
  logic [DATA_W-1:0] tx_data  = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic              busy;
  logic              bit_out;
  logic              mod_out;
  logic              tx_done;

  int   vecs     = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   cm_cnt   = 0;
  int   car_cnt  = 0;
  logic cm_d     = 1'b0;
  logic tick_tb;

  ook_modulator #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_m    (clk_m),
    .carrier  (carrier),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .bit_out  (bit_out),
    .mod_out  (mod_out),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // clock-generator stand-in: registered square waves
  always @(posedge clk) begin
    cm_cnt  <= (cm_cnt == P - 1) ? 0 : cm_cnt + 1;
    clk_m   <= (cm_cnt < P / 2);
    car_cnt <= (car_cnt == CP - 1) ? 0 : car_cnt + 1;
    carrier <= (car_cnt < 2);
    cm_d    <= clk_m;
  end

  assign tick_tb = clk_m & ~cm_d;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns number of negedges consumed up to and including the tick cycle
  task automatic wait_tick(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      @(negedge clk);
      n++;
      if (tick_tb) found = 1'b1;
    end
    chk("tick_seen", 32'(found), 1);
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input bit hold);
    for (int i = 0; i < 12 * P && tx_ready !== 1'b1; i++) @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    chk("accept_busy", 32'(busy), 1);
  endtask

  // checks a whole frame on bit_out/mod_out, then tx_done and return to idle
  task automatic check_frame(input logic [DATA_W-1:0] w, input int exp_lat, input string tag);
    logic [DATA_W+1:0] syms;
    logic              e;
    int                n;
    int                errs;
    int                d0;
    syms = {1'b1, w, 1'b0};
    errs = 0;
    d0   = done_cnt;
    for (int s = 0; s < DATA_W + 2; s++) begin
      e = syms[DATA_W+1-s];
      wait_tick(n);
      if (s == 0 && exp_lat >= 0) chk($sformatf("%s start_lat", tag), 32'(n), 32'(exp_lat));
      for (int i = 1; i < P; i++) begin
        @(negedge clk);
        if (bit_out !== e || mod_out !== (carrier & e)) errs++;
        if (i == P / 2) chk($sformatf("%s sym%0d", tag, s), 32'(bit_out), 32'(e));
      end
    end
    chk($sformatf("%s line_errs", tag), 32'(errs), 0);
    wait_tick(n);
    @(negedge clk);
    chk($sformatf("%s tx_done", tag), 32'(tx_done), 1);
    chk($sformatf("%s ready_after", tag), 32'(tx_ready), 1);
    chk($sformatf("%s bit_idle", tag), 32'(bit_out), 0);
    #1;
    chk($sformatf("%s done_count", tag), 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int n;
    int bad;
    int d0;

    #600000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int d0;

    // reset and idle with clocks running
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst bit_out", 32'(bit_out), 0);
    chk("rst mod_out", 32'(mod_out), 0);
    chk("rst tx_ready", 32'(tx_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst tx_done", 32'(tx_done), 0);
    bad = 0;
    d0  = done_cnt;
    repeat (3 * P) begin
      @(negedge clk);
      if (bit_out !== 1'b0 || mod_out !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle bad_cycles", 32'(bad), 0);
    chk("idle no_done", 32'(done_cnt - d0), 0);

    // single frame 0xA5
    send(8'hA5, 1'b0);
    check_frame(8'hA5, -1, "a5");

    // back-to-back 0xFF then 0x00 with tx_valid held
    @(negedge clk);
    send(8'hFF, 1'b1);
    tx_data = 8'h00;
    check_frame(8'hFF, -1, "b2b_ff");
    check_frame(8'h00, P - 1, "b2b_00");
    tx_valid = 1'b0;

    // tx_valid coincides with a tick in IDLE
    repeat (P) @(negedge clk);
    wait_tick(n);
    chk("coinc idle", 32'(tx_ready), 1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("coinc busy", 32'(busy), 1);
    check_frame(8'h3C, P, "coinc");

    // reset during data bit 4 of 0xFF
    @(negedge clk);
    send(8'hFF, 1'b0);
    repeat (5) wait_tick(n);
    repeat (P / 2) @(negedge clk);
    chk("midrst pre bit", 32'(bit_out), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst bit_out", 32'(bit_out), 0);
    chk("midrst mod_out", 32'(mod_out), 0);
    chk("midrst tx_ready", 32'(tx_ready), 1);
    chk("midrst tx_done", 32'(tx_done), 0);
    bad = 0;
    repeat (2 * P) begin
      @(negedge clk);
      if (bit_out !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    chk("midrst idle_after", 32'(bad), 0);
    chk("midrst no_done", 32'(done_cnt - d0), 0);
    send(8'h81, 1'b0);
    check_frame(8'h81, -1, "post_rst_81");

    // tx_valid toggled with changing data while busy
    @(negedge clk);
    send(8'h5A, 1'b0);
    fork
      check_frame(8'h5A, -1, "toggle_5a");
      begin
        for (int i = 0; i < 4 * P; i++) begin
          @(negedge clk);
          tx_valid = ~tx_valid;
          tx_data  = 8'($urandom);
        end
        tx_valid = 1'b0;
      end
    join
    bad = 0;
    repeat (2 * P) begin
      @(negedge clk);
      if (bit_out !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    chk("toggle no_latch", 32'(bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
